regfile_write_arbiter: RTL

- Shares the register file's single write port (Aw, Dw, WrEn) among NREQ writeback sources, e.g. ALU result, load data and link (ra) write.
- Each source gets a one-entry holding buffer with a valid/ready handshake; a round-robin arbiter picks one buffer per cycle and drives the write port.
- A pending mask shows which architectural registers have writes buffered but not yet committed, so stall/hazard logic can use it.
- Sits between the datapath writeback sources and the register file write inputs.

---
 rtl/regfile_write_arbiter_if.sv | 28 ++
 rtl/regfile_write_arbiter.sv | 95 +++++++++
 2 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Writeback-source / register-file write-port bundle for regfile_write_arbiter.
// Requesters drive the req_* inputs; the arbiter drives the write port and status.
interface regfile_write_arbiter_if #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [ADDR_W-1:0]      Aw;
  logic [DATA_W-1:0]      Dw;
  logic                   WrEn;
  logic [NREQ-1:0]        grant;
  logic [2**ADDR_W-1:0]   pending;
  logic [15:0]            commit_count;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, Aw, Dw, WrEn, grant, pending, commit_count
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, Aw, Dw, WrEn, grant, pending, commit_count
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares one register-file write port among NREQ one-entry writeback buffers,
// round-robin arbitrated, with a pending-address mask for hazard logic.
module regfile_write_arbiter #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input logic                    clk,
  input logic                    rst_n,
  regfile_write_arbiter_if.slave bus
);
  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   full_q;
  logic [ADDR_W-1:0] addr_q [NREQ];
  logic [DATA_W-1:0] data_q [NREQ];
  logic [IdxW-1:0]   last_q;
  logic [15:0]       count_q;

  logic              found;
  logic [IdxW-1:0]   gidx;
  logic [IdxW:0]     idx;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   ready;
  logic [NREQ-1:0]   take;
  logic              wren;

  // Rotating search from last+1; idx carries one extra bit so the wrap is a single subtract.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = '0;
    grant = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx = {1'b0, last_q} + (IdxW+1)'(k + 1);
      if (idx >= (IdxW+1)'(NREQ)) idx = idx - (IdxW+1)'(NREQ);
      if (!found && full_q[idx[IdxW-1:0]]) begin
        found = 1'b1;
        gidx  = idx[IdxW-1:0];
      end
    end
    if (found) grant[gidx] = 1'b1;
  end

  assign ready = ~full_q | grant;
  assign take  = bus.req_valid & ready;

  always_comb begin
    bus.Aw = '0;
    bus.Dw = '0;
    wren   = 1'b0;
    if (found) begin
      bus.Aw = addr_q[gidx];
      bus.Dw = data_q[gidx];
      wren   = |addr_q[gidx];
    end
  end

  // Register 0 is hardwired, so it never shows as pending.
  always_comb begin
    bus.pending = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (full_q[i] && (addr_q[i] != '0)) bus.pending[addr_q[i]] = 1'b1;
    end
  end

  assign bus.WrEn         = wren;
  assign bus.grant        = grant;
  assign bus.req_ready    = ready;
  assign bus.commit_count = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= '0;
      last_q  <= IdxW'(NREQ - 1);
      count_q <= '0;
      for (int i = 0; i < int'(NREQ); i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (take[i]) begin
          full_q[i] <= 1'b1;
          addr_q[i] <= bus.req_addr[i*ADDR_W +: ADDR_W];
          data_q[i] <= bus.req_data[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          full_q[i] <= 1'b0;
        end
      end
      if (found) last_q <= gidx;
      if (wren) count_q <= count_q + 16'd1;
    end
  end
endmodule
